// File: rtl/vga_pkg.sv
// Shared types, widths and the nibble-to-ASCII helper for the VGA text-buffer writers.
package vga_pkg;

  localparam int unsigned TEXT_ADDR_W = 12;
  localparam int unsigned CHAR_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // 0-9 -> '0'..'9', A-F -> 'A'..'F' (uppercase)
  function automatic logic [CHAR_W-1:0] hex2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant from a registered
// priority pointer, which moves past the winner on each accept strobe.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             accept_i,
  output logic [N_REQ-1:0] grant_c_o,
  output logic             any_c_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] winner_c;
  logic [PTR_W-1:0] idx_c;
  logic             found_c;

  // Scan requesters starting at the pointer; first valid one wins
  always_comb begin
    grant_c_o = '0;
    winner_c  = '0;
    found_c   = 1'b0;
    idx_c     = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx_c = PTR_W'((32'(ptr_q) + off) % N_REQ);
      if (!found_c && req_i[idx_c]) begin
        grant_c_o[idx_c] = 1'b1;
        winner_c         = idx_c;
        found_c          = 1'b1;
      end
    end
  end

  assign any_c_o = |req_i;
  assign ptr_d   = (winner_c == PTR_W'(N_REQ - 1)) ? '0 : winner_c + PTR_W'(1);

  // Priority pointer: the requester after the winner becomes highest priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vga_hex_write_arb.sv
// Arbitrates hex-print jobs from several requesters and serialises each into
// eight consecutive ASCII writes on the single text-buffer write port.
module vga_hex_write_arb
  import vga_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = TEXT_ADDR_W,
  parameter int unsigned DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DIGITS*4-1:0] req_value,
  output logic                      display_wen,
  output logic [ADDR_W-1:0]         display_w_addr,
  output logic [CHAR_W-1:0]         display_w_data,
  output logic                      busy
);

  localparam int unsigned VAL_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  base_q;
  logic [VAL_W-1:0]   value_q;
  logic [N_REQ-1:0]   ready_q;
  logic               wen_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [CHAR_W-1:0]  wdata_q;
  logic               busy_q;

  logic [N_REQ-1:0]   grant_c;
  logic               any_c;
  logic               accept_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [VAL_W-1:0]   sel_value_c;

  assign accept_c = (state_q == IDLE) && any_c;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .accept_i  (accept_c),
    .grant_c_o (grant_c),
    .any_c_o   (any_c)
  );

  // Payload of the granted requester
  always_comb begin
    sel_addr_c  = '0;
    sel_value_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        sel_addr_c  = req_addr[i*ADDR_W +: ADDR_W];
        sel_value_c = req_value[i*VAL_W +: VAL_W];
      end
    end
  end

  // Job FSM: accept in IDLE, then one character write per cycle in EMIT.
  // The value is shifted left so the current digit is always the top nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      value_q <= '0;
      ready_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_c) begin
            ready_q <= grant_c;
            base_q  <= sel_addr_c;
            value_q <= sel_value_c;
            cnt_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          wen_q   <= 1'b1;
          busy_q  <= 1'b1;
          waddr_q <= base_q + ADDR_W'(cnt_q);
          wdata_q <= hex2ascii(value_q[VAL_W-1 -: 4]);
          value_q <= value_q << 4;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = ready_q;
  assign display_wen    = wen_q;
  assign display_w_addr = waddr_q;
  assign display_w_data = wdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vga_hex_write_arb.sv
// Bench for vga_hex_write_arb: directed scenarios plus randomized jobs
// checked against a behavioural model of the round-robin print scheduler.
module tb_vga_hex_write_arb;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_value;
  logic            display_wen;
  logic [AW-1:0]   display_w_addr;
  logic [7:0]      display_w_data;
  logic            busy;

  always #5 clk = ~clk;

  vga_hex_write_arb #(.N_REQ(N), .ADDR_W(AW), .DIGITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_value      (req_value),
    .display_wen    (display_wen),
    .display_w_addr (display_w_addr),
    .display_w_data (display_w_data),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed job trace
  logic [N-1:0]  obs_rdy;
  int            obs_t;
  logic          obs_wen[8];
  logic          obs_busy[8];
  logic [N-1:0]  obs_rmid[8];
  logic [AW-1:0] obs_addr[8];
  logic [7:0]    obs_data[8];
  logic          obs_busy_after;
  logic          obs_wen_after;

  // Model: k-th character is hex digit (7-k) of the value, most significant first
  function automatic logic [7:0] m_char(input logic [31:0] v, input int k);
    string hex_s = "0123456789ABCDEF";
    int nib = int'((v >> (4 * (7 - k))) & 32'hF);
    return hex_s[nib];
  endfunction

  // Model: k-th address is base+k modulo the 4096-entry text buffer
  function automatic logic [AW-1:0] m_addr(input logic [AW-1:0] b, input int k);
    return AW'((int'(b) + k) % 4096);
  endfunction

  // Model: first valid requester at or after the pointer, else the lowest valid one
  function automatic int m_winner(input logic [N-1:0] v);
    for (int i = model_ptr; i < int'(N); i++) if (v[i]) return i;
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [31:0] v);
    req_addr[i*AW +: AW]  = a;
    req_value[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Waits (bounded) for an accept, applies keep_mask to the valids, records the 8 write cycles and the one after
  task automatic collect_job(input logic [N-1:0] keep_mask);
    int n = 0;
    while (~|req_ready && n < 40) begin
      tick();
      n++;
    end
    obs_rdy = req_ready;
    obs_t   = cyc;
    req_valid = req_valid & keep_mask;
    for (int k = 0; k < 8; k++) begin
      tick();
      obs_wen[k]  = display_wen;
      obs_busy[k] = busy;
      obs_rmid[k] = req_ready;
      obs_addr[k] = display_w_addr;
      obs_data[k] = display_w_data;
    end
    tick();
    obs_busy_after = busy;
    obs_wen_after  = display_wen;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    set_req(0, 12'h123, 32'h89ABCDEF);
    set_req(1, 12'h456, 32'h01234567);
    repeat (3) tick();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b need 00", req_ready); end
    n_checks++; if (display_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b need 0", display_wen); end
    n_checks++; if (display_w_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h need 000", display_w_addr); end
    n_checks++; if (display_w_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h need 00", display_w_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    req_valid = '0;
    rst = 1'b0;
    model_ptr = 0;
    tick();
  endtask

  task automatic test_single_job();
    set_req(0, 12'h010, 32'h1234ABCD);
    req_valid = 2'b01;
    collect_job('0);
    n_checks++; if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b need 01", obs_rdy); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({obs_wen[k], obs_busy[k], obs_rmid[k], obs_addr[k], obs_data[k]} !== {2'b11, {N{1'b0}}, m_addr(12'h010, k), m_char(32'h1234ABCD, k)}) begin
        n_fail++;
        $display("FAIL single_write%0d: got wen=%b busy=%b rdy=%b addr=%h data=%h need wen=1 busy=1 rdy=0 addr=%h data=%h",
                 k, obs_wen[k], obs_busy[k], obs_rmid[k], obs_addr[k], obs_data[k], m_addr(12'h010, k), m_char(32'h1234ABCD, k));
      end
    end
    n_checks++; if ({obs_busy_after, obs_wen_after} !== 2'b00) begin n_fail++; $display("FAIL single_done: got busy=%b wen=%b need 0 0", obs_busy_after, obs_wen_after); end
    model_ptr = 1;
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_rdy [3] = '{2'b01, 2'b10, 2'b01};
    logic [N-1:0] keep    [3] = '{2'b11, 2'b11, 2'b00};
    logic [AW-1:0] a [2] = '{12'h200, 12'h300};
    logic [31:0]   v [2] = '{32'hCAFE0123, 32'h89ABCDEF};
    int prev_t = 0;
    do_reset();
    set_req(0, a[0], v[0]);
    set_req(1, a[1], v[1]);
    req_valid = 2'b11;
    for (int j = 0; j < 3; j++) begin
      int w;
      w = m_winner(2'b11);
      collect_job(keep[j]);
      n_checks++; if (obs_rdy !== exp_rdy[j] || obs_rdy !== N'(1 << w)) begin n_fail++; $display("FAIL contention_grant%0d: got %b need %b", j, obs_rdy, exp_rdy[j]); end
      if (j > 0) begin
        n_checks++; if (obs_t - prev_t !== 9) begin n_fail++; $display("FAIL contention_gap%0d: got %0d cycles need 9", j, obs_t - prev_t); end
      end
      prev_t = obs_t;
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if ({obs_wen[k], obs_busy[k], obs_addr[k], obs_data[k]} !== {2'b11, m_addr(a[w], k), m_char(v[w], k)}) begin
          n_fail++;
          $display("FAIL contention_write%0d_%0d: got wen=%b busy=%b addr=%h data=%h need addr=%h data=%h",
                   j, k, obs_wen[k], obs_busy[k], obs_addr[k], obs_data[k], m_addr(a[w], k), m_char(v[w], k));
        end
      end
      model_ptr = (w + 1) % int'(N);
    end
  endtask

  task automatic test_addr_wrap();
    set_req(0, 12'hFFE, 32'h0000000F);
    req_valid = 2'b01;
    collect_job('0);
    n_checks++; if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL wrap_ready: got %b need 01", obs_rdy); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({obs_wen[k], obs_addr[k], obs_data[k]} !== {1'b1, m_addr(12'hFFE, k), m_char(32'h0000000F, k)}) begin
        n_fail++;
        $display("FAIL wrap_write%0d: got wen=%b addr=%h data=%h need addr=%h data=%h",
                 k, obs_wen[k], obs_addr[k], obs_data[k], m_addr(12'hFFE, k), m_char(32'h0000000F, k));
      end
    end
    model_ptr = 1;
  endtask

  task automatic test_payload_stability();
    set_req(0, 12'h300, 32'h00000000);
    req_valid = 2'b01;
    fork
      collect_job('0);
      begin
        int n = 0;
        while (!req_ready[0] && n < 40) begin tick(); n++; end
        tick();
        req_value[31:0] = 32'hFFFFFFFF;
        req_addr[AW-1:0] = 12'hABC;
      end
    join
    n_checks++; if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL stable_ready: got %b need 01", obs_rdy); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({obs_wen[k], obs_addr[k], obs_data[k]} !== {1'b1, m_addr(12'h300, k), m_char(32'h0, k)}) begin
        n_fail++;
        $display("FAIL stable_write%0d: got wen=%b addr=%h data=%h need addr=%h data=%h",
                 k, obs_wen[k], obs_addr[k], obs_data[k], m_addr(12'h300, k), m_char(32'h0, k));
      end
    end
    model_ptr = 1;
  endtask

  task automatic test_reset_mid_job();
    int n = 0;
    set_req(0, 12'h100, 32'hDEADBEEF);
    set_req(1, 12'h200, 32'h0BADF00D);
    req_valid = 2'b01;
    while (!req_ready[0] && n < 40) begin tick(); n++; end
    req_valid = '0;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_ready: got %b need 01", req_ready); end
    repeat (4) tick();
    n_checks++; if ({display_wen, display_w_addr, display_w_data} !== {1'b1, 12'h103, 8'h44}) begin
      n_fail++; $display("FAIL midrst_4th: got wen=%b addr=%h data=%h need 1 103 44", display_wen, display_w_addr, display_w_data);
    end
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    n_checks++; if ({display_wen, busy, req_ready} !== '0) begin
      n_fail++; $display("FAIL midrst_abort: got wen=%b busy=%b rdy=%b need 0 0 00", display_wen, busy, req_ready);
    end
    rst = 1'b0;
    model_ptr = 0;
    collect_job('0);
    n_checks++; if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL midrst_regrant: got %b need 01", obs_rdy); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({obs_wen[k], obs_addr[k], obs_data[k]} !== {1'b1, m_addr(12'h100, k), m_char(32'hDEADBEEF, k)}) begin
        n_fail++;
        $display("FAIL midrst_write%0d: got wen=%b addr=%h data=%h need addr=%h data=%h",
                 k, obs_wen[k], obs_addr[k], obs_data[k], m_addr(12'h100, k), m_char(32'hDEADBEEF, k));
      end
    end
    model_ptr = 1;
  endtask

  task automatic test_valid_withdrawn();
    int hits = 0;
    set_req(0, 12'h400, 32'h13579BDF);
    set_req(1, 12'h500, 32'h2468ACE0);
    req_valid = 2'b01;
    fork
      collect_job('0);
      begin
        repeat (3) tick();
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
      end
    join
    n_checks++; if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL withdrawn_ready: got %b need 01", obs_rdy); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({obs_wen[k], obs_rmid[k], obs_addr[k], obs_data[k]} !== {1'b1, {N{1'b0}}, m_addr(12'h400, k), m_char(32'h13579BDF, k)}) begin
        n_fail++;
        $display("FAIL withdrawn_write%0d: got wen=%b rdy=%b addr=%h data=%h need addr=%h data=%h",
                 k, obs_wen[k], obs_rmid[k], obs_addr[k], obs_data[k], m_addr(12'h400, k), m_char(32'h13579BDF, k));
      end
    end
    for (int c = 0; c < 12; c++) begin
      if (req_ready !== 2'b00 || display_wen !== 1'b0) hits++;
      tick();
    end
    n_checks++; if (hits !== 0) begin n_fail++; $display("FAIL withdrawn_quiet: got %0d active cycles need 0", hits); end
    model_ptr = 1;
  endtask

  task automatic test_random();
    logic [AW-1:0] ra [N];
    logic [31:0]   rv [N];
    for (int it = 0; it < 24; it++) begin
      logic [N-1:0] mask;
      int w;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < int'(N); i++) begin
        ra[i] = AW'($urandom);
        rv[i] = $urandom;
        set_req(i, ra[i], rv[i]);
      end
      repeat ($urandom_range(0, 3)) tick();
      req_valid = mask;
      w = m_winner(mask);
      collect_job('0);
      n_checks++; if (obs_rdy !== N'(1 << w)) begin n_fail++; $display("FAIL rand%0d_grant: got %b need %b (valid %b)", it, obs_rdy, N'(1 << w), mask); end
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if ({obs_wen[k], obs_busy[k], obs_rmid[k], obs_addr[k], obs_data[k]} !== {2'b11, {N{1'b0}}, m_addr(ra[w], k), m_char(rv[w], k)}) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got wen=%b busy=%b rdy=%b addr=%h data=%h need addr=%h data=%h",
                   it, k, obs_wen[k], obs_busy[k], obs_rmid[k], obs_addr[k], obs_data[k], m_addr(ra[w], k), m_char(rv[w], k));
        end
      end
      n_checks++; if ({obs_busy_after, obs_wen_after} !== 2'b00) begin n_fail++; $display("FAIL rand%0d_done: got busy=%b wen=%b need 0 0", it, obs_busy_after, obs_wen_after); end
      model_ptr = (w + 1) % int'(N);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_value = '0;
    test_reset();
    test_single_job();
    test_contention();
    test_addr_wrap();
    test_payload_stability();
    test_reset_mid_job();
    test_valid_withdrawn();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks made", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/vga_hex_write_arb.md
# vga_hex_write_arb

Sequential write scheduler for the VGA text buffer's single write port (12-bit address, 8-bit character, one write enable). Several requesters, such as the register debugger and a CPU console, each submit "print this 32-bit value as hex at this screen address" jobs. The block arbitrates between them round-robin and serialises each accepted job into eight consecutive ASCII character writes. It sits between the requesters and the text-display write port, on the 100 MHz clock.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..4)
- ADDR_W, 12, text-buffer address width
- DIGITS, 8, hex digits per job (fixed 8 for 32-bit values)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  100 MHz system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester job request
- req_ready  out  N_REQ  one-hot acceptance pulse; job taken when valid&ready
- req_addr  in  N_REQ*ADDR_W  flattened base address; requester i at [i*ADDR_W +: ADDR_W]
- req_value  in  N_REQ*32  flattened value to print; requester i at [i*32 +: 32]
- display_wen  out  1  text-buffer write enable
- display_w_addr  out  ADDR_W  text-buffer write address
- display_w_data  out  8  ASCII character
- busy  out  1  high while a job is being emitted

## Operation
- FSM has two states:
  - IDLE: if any req_valid, pick a winner by round-robin, pulse req_ready[winner] for one cycle, latch its addr/value, set cnt=0, go to EMIT. With no valid request, stay in IDLE.
  - EMIT: register one write per cycle.
    - display_w_addr = base + cnt, truncated to ADDR_W bits, so 0xFFF+1 wraps to 0x000.
    - display_w_data = hex of nibble (7-cnt), most significant first. Nibble values 0-9 map to 0x30-0x39; values A-F map to 0x41-0x46 (uppercase).
    - When cnt==7, return to IDLE.
- Round-robin: the priority pointer starts at requester 0. After a grant, the requester following the winner becomes highest priority.
- A requester holds valid and its payload stable until ready. The payload is sampled only in the accept cycle; changes after acceptance have no effect.
- Dropping valid before grant is legal. No job is recorded.
- req_ready is never asserted in EMIT. Requesters wait.
- Reset mid-job aborts the job: no further writes, and the partial output is left in the buffer.

## Timing
- Reset values: req_ready=0, display_wen=0, display_w_addr=0, display_w_data=0, busy=0, pointer=0, state IDLE.
- Accept at cycle T (req_ready high). display_wen is high for cycles T+1..T+8 with cnt 0..7. busy is high for T+1..T+8.
- Earliest next accept is T+9, so sustained throughput is one job per 9 cycles with exactly one IDLE cycle between jobs.
- All outputs are registered. No combinational path exists from req_* to display_* or to req_ready.
- Simultaneous valids resolve in a single cycle by the pointer. Exactly one ready bit is high.
- rst high on any edge: outputs take reset values on the following cycle.

## Structure
- Shared package vga_pkg:
  - constants TEXT_ADDR_W=12 and CHAR_W=8
  - state enum {IDLE, EMIT}
  - function hex2ascii(4-bit) -> 8-bit
- One sub-module, rr_arbiter: N_REQ-wide round-robin grant with a pointer update on an accept strobe. It is reusable for other shared display ports.
- The top level contains the FSM, the 3-bit digit counter, the latched job registers and the output registers.

## Test plan
- Single job: req0 addr=0x010, value=0x1234ABCD, accepted at T -> writes at T+1..T+8 to 0x010..0x017 with data 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44; busy low at T+9.
- Contention: req0 and req1 both valid after reset -> req0 granted at T, req1 at T+9. With both still valid, req0 again at T+18. Strict alternation, no starvation.
- Address wrap: addr=0xFFE, value=0x0000000F -> addresses 0xFFE,0xFFF,0x000..0x005; data 0x30 ×7 then 0x46.
- Payload stability: change req_value to 0xFFFFFFFF at T+1 after accepting 0x00000000 -> all eight writes are 0x30.
- Reset mid-job: assert rst during the 4th write (T+4) -> from T+5, display_wen=0, busy=0, req_ready=0. After release with both valid, req0 is granted first (pointer reset).
- Valid withdrawn: req1 raises valid for one cycle while a req0 job is in EMIT, then drops it -> req1 is never granted and no writes occur for it.
